vga_syncgen: RTL and testbench

//  - Consumes the 25 MHz pixel clock PCK from the MMCM clock stage. Generates 640x480@60 VGA timing:

---
 rtl/syncgen_pkg.sv | 25 ++
 rtl/syncgen_axis.sv | 48 ++++
 rtl/vga_syncgen.sv | 119 +++++++++++
 tb/tb_vga_syncgen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/syncgen_pkg.sv
// Shared timing defaults and counter width for the VGA sync generator.
// Defaults describe 640x480@60 on a 25 MHz pixel clock.
package syncgen_pkg;

  localparam int CNTW = 10;

  localparam int DEF_HDISP  = 640;
  localparam int DEF_HFRONT = 16;
  localparam int DEF_HWIDTH = 96;
  localparam int DEF_HBACK  = 48;

  localparam int DEF_VDISP  = 480;
  localparam int DEF_VFRONT = 10;
  localparam int DEF_VWIDTH = 2;
  localparam int DEF_VBACK  = 33;

  function automatic int axis_period(input int disp, input int front,
                                     input int width, input int back);
    return disp + front + width + back;
  endfunction

  localparam int DEF_HPERIOD = axis_period(DEF_HDISP, DEF_HFRONT, DEF_HWIDTH, DEF_HBACK);
  localparam int DEF_VPERIOD = axis_period(DEF_VDISP, DEF_VFRONT, DEF_VWIDTH, DEF_VBACK);

endpackage

// File: rtl/syncgen_axis.sv
// One timing axis: wrapping counter with enable, terminal-count flag and a
// registered active-low sync decode of the current count.
module syncgen_axis
  import syncgen_pkg::*;
#(
  parameter int PERIOD     = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_WIDTH = 96
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [CNTW-1:0] cnt,
  output logic            tc,
  output logic            sync_n
);

  localparam logic [CNTW-1:0] LAST    = CNTW'(PERIOD - 1);
  localparam logic [CNTW-1:0] SYNC_LO = CNTW'(SYNC_START);
  localparam logic [CNTW-1:0] SYNC_HI = CNTW'(SYNC_START + SYNC_WIDTH - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            sync_n_q, sync_n_d;

  always_comb begin
    tc    = (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNTW'(1);
    end
    // Decoded every cycle, so the pulse trails the count by exactly one clock.
    sync_n_d = !((cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sync_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign cnt    = cnt_q;
  assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_syncgen.sv
// VGA timing generator: free-running H/V counters, registered HSYNC/VSYNC/DE.
// Defining SYNCGEN_FRAMECNT_EN adds FRAMECNT and FRAME_TICK.
module vga_syncgen
  import syncgen_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFRONT = DEF_HFRONT,
  parameter int HWIDTH = DEF_HWIDTH,
  parameter int HBACK  = DEF_HBACK,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFRONT = DEF_VFRONT,
  parameter int VWIDTH = DEF_VWIDTH,
  parameter int VBACK  = DEF_VBACK
) (
  input  logic            PCK,
  input  logic            RST,
  input  logic            LOCKED,
  output logic [CNTW-1:0] HCNT,
  output logic [CNTW-1:0] VCNT,
  output logic            HSYNC,
  output logic            VSYNC,
  output logic            DE
`ifdef SYNCGEN_FRAMECNT_EN
  ,
  output logic [7:0]      FRAMECNT,
  output logic            FRAME_TICK
`endif
);

  // Both periods must fit the 10-bit counters (<= 1024).
  localparam int HPERIOD = axis_period(HDISP, HFRONT, HWIDTH, HBACK);
  localparam int VPERIOD = axis_period(VDISP, VFRONT, VWIDTH, VBACK);

  localparam logic [CNTW-1:0] HDISP_C = CNTW'(HDISP);
  localparam logic [CNTW-1:0] VDISP_C = CNTW'(VDISP);

  logic            rst_int;
  logic [CNTW-1:0] h_cnt, v_cnt;
  logic            h_tc, v_tc;
  logic            h_sync_n, v_sync_n;
  logic            de_q, de_d;

  assign rst_int = RST | ~LOCKED;

  syncgen_axis #(
    .PERIOD     (HPERIOD),
    .SYNC_START (HDISP + HFRONT),
    .SYNC_WIDTH (HWIDTH)
  ) u_h_axis (
    .clk    (PCK),
    .rst    (rst_int),
    .en     (1'b1),
    .cnt    (h_cnt),
    .tc     (h_tc),
    .sync_n (h_sync_n)
  );

  syncgen_axis #(
    .PERIOD     (VPERIOD),
    .SYNC_START (VDISP + VFRONT),
    .SYNC_WIDTH (VWIDTH)
  ) u_v_axis (
    .clk    (PCK),
    .rst    (rst_int),
    .en     (h_tc),
    .cnt    (v_cnt),
    .tc     (v_tc),
    .sync_n (v_sync_n)
  );

  always_comb begin
    de_d = (h_cnt < HDISP_C) && (v_cnt < VDISP_C);
  end

  always_ff @(posedge PCK) begin
    if (rst_int) begin
      de_q <= 1'b0;
    end else begin
      de_q <= de_d;
    end
  end

  assign HCNT  = h_cnt;
  assign VCNT  = v_cnt;
  assign HSYNC = h_sync_n;
  assign VSYNC = v_sync_n;
  assign DE    = de_q;

`ifdef SYNCGEN_FRAMECNT_EN
  logic [7:0] framecnt_q, framecnt_d;
  logic       frame_tick_q, frame_tick_d;

  always_comb begin
    framecnt_d = framecnt_q;
    if (h_tc && v_tc) begin
      framecnt_d = framecnt_q + 8'd1;
    end
    // Lines up with the first DE cycle of the frame.
    frame_tick_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge PCK) begin
    if (rst_int) begin
      framecnt_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      framecnt_q   <= framecnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign FRAMECNT   = framecnt_q;
  assign FRAME_TICK = frame_tick_q;
`else
  logic unused_v_tc;
  assign unused_v_tc = v_tc;
`endif

endmodule

// File: tb/tb_vga_syncgen.sv
// Bench for vga_syncgen: full-size instance for line timing, shrunken instance for frame behaviour.
module tb_vga_syncgen;

  localparam int S_HD = 8, S_HF = 2, S_HW = 3, S_HB = 3;
  localparam int S_VD = 4, S_VF = 1, S_VW = 2, S_VB = 1;
  localparam int S_FRAME = (S_HD + S_HF + S_HW + S_HB) * (S_VD + S_VF + S_VW + S_VB);

  logic       PCK = 1'b0;
  logic       RST = 1'b1;
  logic       LOCKED = 1'b1;
  logic [9:0] hcnt_a, vcnt_a, hcnt_b, vcnt_b;
  logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;
`ifdef SYNCGEN_FRAMECNT_EN
  logic [7:0] fc_a, fc_b;
  logic       ft_a, ft_b;
`endif

  int checks = 0;
  int errors = 0;

  always #20 PCK = ~PCK;

  vga_syncgen u_full (
    .PCK(PCK), .RST(RST), .LOCKED(LOCKED),
    .HCNT(hcnt_a), .VCNT(vcnt_a), .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a)
`ifdef SYNCGEN_FRAMECNT_EN
    , .FRAMECNT(fc_a), .FRAME_TICK(ft_a)
`endif
  );

  vga_syncgen #(
    .HDISP(S_HD), .HFRONT(S_HF), .HWIDTH(S_HW), .HBACK(S_HB),
    .VDISP(S_VD), .VFRONT(S_VF), .VWIDTH(S_VW), .VBACK(S_VB)
  ) u_small (
    .PCK(PCK), .RST(RST), .LOCKED(LOCKED),
    .HCNT(hcnt_b), .VCNT(vcnt_b), .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b)
`ifdef SYNCGEN_FRAMECNT_EN
    , .FRAMECNT(fc_b), .FRAME_TICK(ft_b)
`endif
  );

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic [31:0] fc;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ft;
  } exp_t;

  // Expected outputs n edges after the last reset edge, straight from the timing rules.
  function automatic exp_t model(input int n, input bit rst_edge,
                                 input int hd, input int hf, input int hw, input int hb,
                                 input int vd, input int vf, input int vw, input int vb);
    exp_t e;
    int hp, vp, p, ph, pv;
    hp = hd + hf + hw + hb;
    vp = vd + vf + vw + vb;
    e.h = 0; e.v = 0; e.fc = 0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.ft = 1'b0;
    if (!rst_edge) begin
      p  = n - 1;
      ph = p % hp;
      pv = (p / hp) % vp;
      e.h  = n % hp;
      e.v  = (n / hp) % vp;
      e.hs = !(ph >= hd + hf && ph < hd + hf + hw);
      e.vs = !(pv >= vd + vf && pv < vd + vf + vw);
      e.de = (ph < hd) && (pv < vd);
      e.fc = (n / (hp * vp)) % 256;
      e.ft = (ph == 0) && (pv == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  int n_q       = 0;
  bit rst_edge  = 1'b1;
  bit started   = 1'b0;

  always @(posedge PCK) begin
    if (RST || !LOCKED) begin
      n_q      <= 0;
      rst_edge <= 1'b1;
      started  <= 1'b1;
    end else begin
      n_q      <= n_q + 1;
      rst_edge <= 1'b0;
    end
  end

  always @(negedge PCK) begin
    exp_t ea, eb;
    if (started) begin
      ea = model(n_q, rst_edge, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = model(n_q, rst_edge, S_HD, S_HF, S_HW, S_HB, S_VD, S_VF, S_VW, S_VB);
      chk("full_hcnt",  int'(hcnt_a), int'(ea.h));
      chk("full_vcnt",  int'(vcnt_a), int'(ea.v));
      chk("full_hsync", int'(hs_a),   int'(ea.hs));
      chk("full_vsync", int'(vs_a),   int'(ea.vs));
      chk("full_de",    int'(de_a),   int'(ea.de));
      chk("small_hcnt",  int'(hcnt_b), int'(eb.h));
      chk("small_vcnt",  int'(vcnt_b), int'(eb.v));
      chk("small_hsync", int'(hs_b),   int'(eb.hs));
      chk("small_vsync", int'(vs_b),   int'(eb.vs));
      chk("small_de",    int'(de_b),   int'(eb.de));
`ifdef SYNCGEN_FRAMECNT_EN
      chk("full_framecnt",  int'(fc_a), int'(ea.fc));
      chk("full_frametick", int'(ft_a), int'(ea.ft));
      chk("small_framecnt",  int'(fc_b), int'(eb.fc));
      chk("small_frametick", int'(ft_b), int'(eb.ft));
`endif
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_hcnt_a"}, int'(hcnt_a), 0);
    chk({tag, "_vcnt_a"}, int'(vcnt_a), 0);
    chk({tag, "_hsync_a"}, int'(hs_a), 1);
    chk({tag, "_vsync_a"}, int'(vs_a), 1);
    chk({tag, "_de_a"}, int'(de_a), 0);
    chk({tag, "_hcnt_b"}, int'(hcnt_b), 0);
    chk({tag, "_vcnt_b"}, int'(vcnt_b), 0);
    chk({tag, "_de_b"}, int'(de_b), 0);
`ifdef SYNCGEN_FRAMECNT_EN
    chk({tag, "_framecnt_a"}, int'(fc_a), 0);
    chk({tag, "_frametick_a"}, int'(ft_a), 0);
    chk({tag, "_framecnt_b"}, int'(fc_b), 0);
`endif
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, guard;
    int ft_cnt, ft_last, start_cnt, start_last, vs_low, de_frames, wraps;
    int prev_h, prev_v;
    bit found;

    RST = 1'b1;
    LOCKED = 1'b1;
    repeat (3) @(negedge PCK);
    chk_reset_values("reset");

    RST = 1'b0;
    @(negedge PCK);
    chk("release_hcnt", int'(hcnt_a), 1);
    chk("release_vcnt", int'(vcnt_a), 0);
    chk("release_de", int'(de_a), 1);
    chk("release_small_hcnt", int'(hcnt_b), 1);

    // First full line: DE width, HSYNC width and HSYNC start position.
    de_cnt = 0; hs_cnt = 0; hs_first = -1;
    for (int i = 0; i < 800; i++) begin
      if (de_a) de_cnt++;
      if (!hs_a) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcnt_a);
      end
      @(negedge PCK);
    end
    chk("line_de_cycles", de_cnt, 640);
    chk("line_hsync_cycles", hs_cnt, 96);
    chk("line_hsync_first_hcnt", hs_first, 657);

    found = 1'b0;
    for (guard = 0; guard < 4000 && !found; guard++) begin
      if (hcnt_a == 10'd300 && vcnt_a == 10'd2) found = 1'b1;
      else @(negedge PCK);
    end
    chk("reach_hcnt300_found", int'(found), 1);

    LOCKED = 1'b0;
    @(negedge PCK);
    chk_reset_values("unlock");
    LOCKED = 1'b1;
    @(negedge PCK);
    chk("relock_hcnt", int'(hcnt_a), 1);
    chk("relock_vcnt", int'(vcnt_a), 0);
    chk("relock_small_hcnt", int'(hcnt_b), 1);

    // Three small frames after relock: samples n = 1 .. 3*S_FRAME.
    ft_cnt = 0; ft_last = -1; start_cnt = 0; start_last = -1;
    vs_low = 0; de_frames = 0; wraps = 0;
    prev_h = 0; prev_v = 0;
    for (int i = 1; i <= 3 * S_FRAME; i++) begin
      if (de_b) de_frames++;
      if (!vs_b) begin
        vs_low++;
        chk("vsync_line_in_range", int'(prev_v >= 5 && prev_v <= 6), 1);
      end
      if (prev_h == 15 && prev_v == 7) begin
        wraps++;
        chk("wrap_hcnt", int'(hcnt_b), 0);
        chk("wrap_vcnt", int'(vcnt_b), 0);
      end
      if (hcnt_b == 10'd0 && vcnt_b == 10'd0) begin
        if (start_last >= 0) chk("frame_period", i - start_last, S_FRAME);
        start_last = i;
        start_cnt++;
      end
`ifdef SYNCGEN_FRAMECNT_EN
      if (ft_b) begin
        if (ft_last >= 0) chk("frametick_spacing", i - ft_last, S_FRAME);
        ft_last = i;
        ft_cnt++;
      end
`endif
      prev_h = int'(hcnt_b);
      prev_v = int'(vcnt_b);
      if (i < 3 * S_FRAME) @(negedge PCK);
    end
    chk("frames_de_cycles", de_frames, 3 * 32);
    chk("frames_vsync_low_cycles", vs_low, 3 * 2 * 16);
    chk("frames_wraps", wraps, 3);
    chk("frames_starts", start_cnt, 3);
`ifdef SYNCGEN_FRAMECNT_EN
    chk("frames_ticks", ft_cnt, 3);
    chk("frames_framecnt", int'(fc_b), 3);

    // Carry on to 256 completed small frames so FRAMECNT wraps to 0.
    repeat (256 * S_FRAME - 3 * S_FRAME) @(negedge PCK);
    chk("framecnt_256_wrap", int'(fc_b), 0);
    chk("framecnt_256_hcnt", int'(hcnt_b), 0);
    @(negedge PCK);
    chk("framecnt_256_tick", int'(ft_b), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
